// File: rtl/game_screen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_screen_ctrl
//  Brief    : Snake-game screen sequencer. Play/fail state machine, elapsed
//             seconds timer, score freeze with serial double-dabble BCD
//             conversion, and game/fail pixel selection for the VGA driver.
//             Optional pause feature enabled by defining SCREEN_PAUSE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module game_screen_ctrl #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int FAIL_HOLD_S = 3,
  parameter int SEC_MAX     = 999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        collide,
  input  logic [10:0] length,
  input  logic [15:0] pixel_game,
  input  logic [15:0] pixel_fail,
`ifdef SCREEN_PAUSE_EN
  input  logic        pause,
`endif
  output logic [15:0] pixel_data,
  output logic        game_run,
  output logic        game_rst,
  output logic [9:0]  second,
  output logic [11:0] bcd_sec,
  output logic [7:0]  bcd_len,
  output logic        bcd_valid
);

  localparam int                TICK_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int                HOLD_W    = $clog2(FAIL_HOLD_S + 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAIL_HOLD_S);
  localparam logic [9:0]        SEC_SAT   = 10'(SEC_MAX);

`ifdef SCREEN_PAUSE_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PLAY = 3'd1, S_CONV = 3'd2, S_FAIL = 3'd3, S_PAUSE = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_PLAY = 2'd1, S_CONV = 2'd2, S_FAIL = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [9:0]          second_q, second_d;
  logic [3:0]          iter_q, iter_d;
  // Shift registers laid out as {hundreds, tens, ones, binary[9:0]}
  logic [21:0]         sec_sr_q, sec_sr_d;
  logic [21:0]         len_sr_q, len_sr_d;
  logic [11:0]         bcd_sec_q, bcd_sec_d;
  logic [7:0]          bcd_len_q, bcd_len_d;
  logic                valid_q, valid_d;
  logic                run_q, run_d;
  logic                grst_q, grst_d;
  logic [15:0]         pix_q, pix_d;

  logic                w_tick_wrap;
  logic                w_hold_done;
  logic                w_start_game;
  logic [9:0]          w_len_clip;
  logic [21:0]         w_sec_step;
  logic [21:0]         w_len_step;

  // One double-dabble iteration: correct every BCD digit >= 5, then shift left
  function automatic logic [21:0] dd_step(input logic [21:0] v);
    logic [21:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  assign w_tick_wrap = (tick_q == TICK_LAST);
  // Restart is allowed on the edge where the last required second completes
  assign w_hold_done = (hold_q >= HOLD_LAST) ||
                       (w_tick_wrap && ((hold_q + HOLD_W'(1)) >= HOLD_LAST));
  assign w_len_clip  = (length > 11'd99) ? 10'd99 : length[9:0];
  assign w_sec_step  = dd_step(sec_sr_q);
  assign w_len_step  = dd_step(len_sr_q);

  // Next-state, counter and conversion logic
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    hold_d       = hold_q;
    second_d     = second_q;
    iter_d       = iter_q;
    sec_sr_d     = sec_sr_q;
    len_sr_d     = len_sr_q;
    bcd_sec_d    = bcd_sec_q;
    bcd_len_d    = bcd_len_q;
    valid_d      = valid_q;
    grst_d       = 1'b0;
    w_start_game = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) w_start_game = 1'b1;
      end
      S_PLAY: begin
        if (collide) begin
          // Freeze the score; a tick landing on this edge is dropped
          state_d  = S_CONV;
          iter_d   = 4'd0;
          sec_sr_d = {12'd0, second_q};
          len_sr_d = {12'd0, w_len_clip};
`ifdef SCREEN_PAUSE_EN
        end else if (pause) begin
          state_d = S_PAUSE;
`endif
        end else begin
          tick_d = w_tick_wrap ? '0 : tick_q + TICK_W'(1);
          if (w_tick_wrap && (second_q < SEC_SAT)) second_d = second_q + 10'd1;
        end
      end
      S_CONV: begin
        sec_sr_d = w_sec_step;
        len_sr_d = w_len_step;
        iter_d   = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          bcd_sec_d = w_sec_step[21:10];
          bcd_len_d = w_len_step[17:10];
          valid_d   = 1'b1;
          state_d   = S_FAIL;
          tick_d    = '0;
          hold_d    = '0;
        end
      end
      S_FAIL: begin
        tick_d = w_tick_wrap ? '0 : tick_q + TICK_W'(1);
        if (w_tick_wrap && (hold_q < HOLD_LAST)) hold_d = hold_q + HOLD_W'(1);
        if (start && w_hold_done) w_start_game = 1'b1;
      end
`ifdef SCREEN_PAUSE_EN
      S_PAUSE: begin
        if (pause) state_d = S_PLAY;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (w_start_game) begin
      state_d  = S_PLAY;
      tick_d   = '0;
      second_d = 10'd0;
      valid_d  = 1'b0;
      grst_d   = 1'b1;
    end
  end

  assign run_d = (state_d == S_PLAY);
  assign pix_d = (state_q == S_FAIL) ? pixel_fail : pixel_game;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      hold_q    <= '0;
      second_q  <= 10'd0;
      iter_q    <= 4'd0;
      sec_sr_q  <= 22'd0;
      len_sr_q  <= 22'd0;
      bcd_sec_q <= 12'd0;
      bcd_len_q <= 8'd0;
      valid_q   <= 1'b0;
      run_q     <= 1'b0;
      grst_q    <= 1'b0;
      pix_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      second_q  <= second_d;
      iter_q    <= iter_d;
      sec_sr_q  <= sec_sr_d;
      len_sr_q  <= len_sr_d;
      bcd_sec_q <= bcd_sec_d;
      bcd_len_q <= bcd_len_d;
      valid_q   <= valid_d;
      run_q     <= run_d;
      grst_q    <= grst_d;
      pix_q     <= pix_d;
    end
  end

  assign pixel_data = pix_q;
  assign game_run   = run_q;
  assign game_rst   = grst_q;
  assign second     = second_q;
  assign bcd_sec    = bcd_sec_q;
  assign bcd_len    = bcd_len_q;
  assign bcd_valid  = valid_q;

endmodule
`default_nettype wire
